// File: rtl/modular_exp_unit.sv
// Right-to-left square-and-multiply modular exponentiation, r = m^e mod n.
// Bit-serial interleaved multipliers give fixed, data-independent latency.
module modular_exp_unit #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [BITS-1:0] m,
    input  logic [BITS-1:0] e,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] r,
    output logic            d
);

    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_EXP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] m_q, m_d;
    logic [BITS-1:0] e_q, e_d;
    logic [BITS-1:0] n_q, n_d;
    logic [BITS-1:0] base_q, base_d;
    logic [BITS-1:0] acc_q, acc_d;
    logic [BITS:0]   pr_q, pr_d;
    logic [BITS+1:0] pm_q, pm_d;
    logic [BITS+1:0] ps_q, ps_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   eb_q, eb_d;
    logic [BITS-1:0] r_q, r_d;
    logic            d_q, d_d;

    logic [BITS:0]   pr_nx;
    logic [BITS+1:0] pm_nx;
    logic [BITS+1:0] ps_nx;
    logic            b_bit;

    // One MSB-first restoring reduction step; p < n keeps 2p+1 in BITS+1 bits.
    function automatic logic [BITS:0] red_step(
        input logic [BITS:0]   p,
        input logic            bb,
        input logic [BITS-1:0] nn
    );
        logic [BITS:0] t;
        t = (p << 1) | {{BITS{1'b0}}, bb};
        if (t >= {1'b0, nn}) t = t - {1'b0, nn};
        return t;
    endfunction

    // Interleaved multiply step; 2p+a < 3n, so two subtractions suffice.
    function automatic logic [BITS+1:0] mul_step(
        input logic [BITS+1:0] p,
        input logic [BITS-1:0] a,
        input logic            bb,
        input logic [BITS-1:0] nn
    );
        logic [BITS+1:0] t;
        t = p << 1;
        if (bb) t = t + {2'b00, a};
        if (t >= {2'b00, nn}) t = t - {2'b00, nn};
        if (t >= {2'b00, nn}) t = t - {2'b00, nn};
        return t;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            pr_q    <= '0;
            pm_q    <= '0;
            ps_q    <= '0;
            idx_q   <= '0;
            eb_q    <= '0;
            r_q     <= '0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            pr_q    <= pr_d;
            pm_q    <= pm_d;
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            eb_q    <= eb_d;
            r_q     <= r_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        n_d     = n_q;
        base_d  = base_q;
        acc_d   = acc_q;
        pr_d    = pr_q;
        pm_d    = pm_q;
        ps_d    = ps_q;
        idx_d   = idx_q;
        eb_d    = eb_q;
        r_d     = r_q;
        d_d     = 1'b0;

        b_bit = base_q[idx_q];
        pr_nx = red_step(pr_q, m_q[idx_q], n_q);
        pm_nx = mul_step(pm_q, acc_q, b_bit, n_q);
        ps_nx = mul_step(ps_q, base_q, b_bit, n_q);

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    m_d     = m;
                    e_d     = e;
                    n_d     = n;
                    pr_d    = '0;
                    idx_d   = LAST;
                    eb_d    = LAST;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                pr_d = pr_nx;
                if (idx_q == '0) begin
                    base_d  = pr_nx[BITS-1:0];
                    acc_d   = (n_q > BITS'(1)) ? BITS'(1) : '0;
                    pm_d    = '0;
                    ps_d    = '0;
                    idx_d   = LAST;
                    state_d = S_EXP;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_EXP: begin
                pm_d = pm_nx;
                ps_d = ps_nx;
                if (idx_q == '0) begin
                    // Multiply always runs; e bit only selects the result.
                    acc_d  = e_q[0] ? pm_nx[BITS-1:0] : acc_q;
                    base_d = ps_nx[BITS-1:0];
                    e_d    = e_q >> 1;
                    pm_d   = '0;
                    ps_d   = '0;
                    idx_d  = LAST;
                    if (eb_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        eb_d = eb_q - 1'b1;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                r_d     = acc_q;
                d_d     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign r = r_q;
    assign d = d_q;

endmodule

// File: tb/tb_modular_exp_unit.sv
// Scoreboard bench for modular_exp_unit: results and d timing per go.
module tb_modular_exp_unit;

    localparam int BITS = 4;
    localparam int LAT  = BITS + BITS * BITS + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            go = 1'b0;
    logic [BITS-1:0] m = '0;
    logic [BITS-1:0] e = '0;
    logic [BITS-1:0] n = '0;
    logic [BITS-1:0] r;
    logic            d;

    modular_exp_unit #(.BITS(BITS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (go),
        .m    (m),
        .e    (e),
        .n    (n),
        .r    (r),
        .d    (d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] res;
        int              due;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    int              npulse = 0;
    int              ngo = 0;
    int              naborted = 0;
    logic [BITS-1:0] prev_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d === 1'b1) begin
            exp_t x;
            npulse++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_d cyc=%0d r=%0d", cyc, r);
            end else begin
                x = sb.pop_front();
                if (r !== x.res) begin
                    errors++;
                    $display("FAIL result got=%0d exp=%0d", r, x.res);
                end
                checks++;
                if (cyc !== x.due) begin
                    errors++;
                    $display("FAIL d_timing got=%0d exp=%0d", cyc, x.due);
                end
            end
        end else if (rst_n === 1'b1) begin
            checks++;
            if (r !== prev_r) begin
                errors++;
                $display("FAIL r_hold got=%0d exp=%0d", r, prev_r);
            end
        end
        prev_r = r;
    end

    function automatic logic [BITS-1:0] ref_exp(input int mm, input int ee, input int nn);
        int b;
        int a;
        if (nn == 0) return '0;
        b = mm % nn;
        a = 1 % nn;
        for (int i = 0; i < BITS; i++) begin
            if (ee[i]) a = (a * b) % nn;
            b = (b * b) % nn;
        end
        return BITS'(a);
    endfunction

    // Call at a negedge; the following posedge samples go.
    task automatic start(input logic [BITS-1:0] mm, input logic [BITS-1:0] ee,
                         input logic [BITS-1:0] nn, input logic [BITS-1:0] ev);
        m  = mm;
        e  = ee;
        n  = nn;
        go = 1'b1;
        ngo++;
        sb.push_back('{res: ev, due: cyc + LAT + 1});
    endtask

    task automatic wait_d();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (d === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL d_timeout cyc=%0d got=0 exp=1", cyc);
    endtask

    task automatic run1(input logic [BITS-1:0] mm, input logic [BITS-1:0] ee,
                        input logic [BITS-1:0] nn, input logic [BITS-1:0] ev);
        @(negedge clk);
        start(mm, ee, nn, ev);
        @(negedge clk);
        go = 1'b0;
        wait_d();
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        go    = 1'b1;
        m     = 4'd3;
        e     = 4'd3;
        n     = 4'd5;
        repeat (3) @(negedge clk);
        checks++;
        if (r !== '0) begin
            errors++;
            $display("FAIL reset_r got=%0d exp=0", r);
        end
        checks++;
        if (d !== 1'b0) begin
            errors++;
            $display("FAIL reset_d got=%0d exp=0", d);
        end
        go    = 1'b0;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (d !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_d got=1 exp=0");
        end
    endtask

    task automatic test_basic();
        run1(4'd4, 4'd13, 4'd7, 4'd4);
        repeat (5) @(negedge clk);
        checks++;
        if (r !== 4'd4) begin
            errors++;
            $display("FAIL basic_hold got=%0d exp=4", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] tm[5] = '{4'd5, 4'd6, 4'd3, 4'd9, 4'd5};
        logic [BITS-1:0] te[5] = '{4'd2, 4'd3, 4'd7, 4'd3, 4'd5};
        logic [BITS-1:0] tn[5] = '{4'd9, 4'd13, 4'd8, 4'd13, 4'd7};
        logic [BITS-1:0] tr[5] = '{4'd7, 4'd8, 4'd3, 4'd1, 4'd3};
        @(negedge clk);
        start(tm[0], te[0], tn[0], tr[0]);
        for (int i = 1; i < 5; i++) begin
            wait_d();
            start(tm[i], te[i], tn[i], tr[i]);
        end
        wait_d();
        go = 1'b0;
    endtask

    task automatic test_boundary();
        logic [BITS-1:0] tm[5] = '{4'd7, 4'd9, 4'd3, 4'd15, 4'd14};
        logic [BITS-1:0] te[5] = '{4'd0, 4'd3, 4'd2, 4'd15, 4'd1};
        logic [BITS-1:0] tn[5] = '{4'd5, 4'd1, 4'd0, 4'd15, 4'd11};
        logic [BITS-1:0] tr[5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd3};
        for (int i = 0; i < 5; i++) run1(tm[i], te[i], tn[i], tr[i]);
    endtask

    task automatic test_midchange();
        @(negedge clk);
        start(4'd11, 4'd7, 4'd13, 4'd2);
        repeat (18) begin
            @(negedge clk);
            go = 1'($urandom);
            m  = BITS'($urandom);
            e  = BITS'($urandom);
            n  = BITS'($urandom);
        end
        go = 1'b0;
        wait_d();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start(4'd7, 4'd9, 4'd11, ref_exp(7, 9, 11));
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (r !== '0) begin
            errors++;
            $display("FAIL async_rst_r got=%0d exp=0", r);
        end
        checks++;
        if (d !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_d got=%0d exp=0", d);
        end
        sb.delete();
        naborted++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start(4'd2, 4'd10, 4'd15, 4'd4);
        @(negedge clk);
        go = 1'b0;
        wait_d();
    endtask

    task automatic test_sweep();
        int ev[4];
        for (int nn = 0; nn < 16; nn++) begin
            for (int mm = 0; mm < 16; mm++) begin
                ev[0] = 0;
                ev[1] = 1;
                ev[2] = 15;
                ev[3] = int'($urandom_range(2, 14));
                for (int k = 0; k < 4; k++) begin
                    run1(BITS'(mm), BITS'(ev[k]), BITS'(nn), ref_exp(mm, ev[k], nn));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_midchange();
        test_reset_mid();
        test_sweep();
        repeat (30) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL pending got=%0d exp=0", sb.size());
        end
        checks++;
        if (npulse !== ngo - naborted) begin
            errors++;
            $display("FAIL pulse_count got=%0d exp=%0d", npulse, ngo - naborted);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
